sobel_window_gen: RTL and testbench

- Upstream stage of the Sobel datapath.
- Accepts a raster-order pixel stream and buffers two image lines.
- Emits one 3x3 neighbourhood per interior pixel to the gradient stage, whose sobel_add_nb adders form Gx/Gy.
- Valid/ready handshakes on both sides; frame position is tracked by internal column and row counters.

---
 rtl/sobel_window_gen.sv | 111 +++++++++++
 tb/tb_sobel_window_gen.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_window_gen.sv
// Sobel front end: buffers two image lines and emits one 3x3 neighbourhood per
// interior pixel of a raster-order stream, with valid/ready on both sides.
module sobel_window_gen #(
  parameter int bitwidth = 8,
  parameter int IMG_W    = 16,
  parameter int IMG_H    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic [bitwidth-1:0]   pix_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [9*bitwidth-1:0] win_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0]       col;
  logic [RW-1:0]       row;
  logic [bitwidth-1:0] lb_top [IMG_W];
  logic [bitwidth-1:0] lb_mid [IMG_W];
  logic [bitwidth-1:0] win      [9];
  logic [bitwidth-1:0] next_win [9];
  logic [9*bitwidth-1:0] next_flat;
  logic [bitwidth-1:0] top_px;
  logic [bitwidth-1:0] mid_px;
  logic                accept;
  logic                emit;
  logic                col_last;
  logic                row_last;

  // clear takes priority: the pixel presented alongside it is dropped
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !clear;
  assign col_last = (col == CW'(IMG_W - 1));
  assign row_last = (row == RW'(IMG_H - 1));
  assign emit     = accept && (row >= RW'(2)) && (col >= CW'(2));
  assign top_px   = lb_top[col];
  assign mid_px   = lb_mid[col];

  always_comb begin
    for (int k = 0; k < 9; k++) next_win[k] = win[k];
    for (int r = 0; r < 3; r++) begin
      next_win[r*3]     = win[r*3 + 1];
      next_win[r*3 + 1] = win[r*3 + 2];
    end
    next_win[2] = top_px;
    next_win[5] = mid_px;
    next_win[8] = pix_in;
    next_flat = '0;
    for (int k = 0; k < 9; k++) next_flat[k*bitwidth +: bitwidth] = next_win[k];
  end

  // Line RAM is deliberately not reset; stale data is masked by the row>=2 rule
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_top[col] <= mid_px;
      lb_mid[col] <= pix_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 9; k++) win[k] <= '0;
    end else if (accept) begin
      for (int k = 0; k < 9; k++) win[k] <= next_win[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // An emit together with out_ready reloads the window without a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      win_out    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept && col_last && row_last;
      if (clear) begin
        out_valid <= 1'b0;
      end else if (emit) begin
        out_valid <= 1'b1;
        win_out   <= next_flat;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sobel_window_gen.sv
// Scoreboard bench for sobel_window_gen: a 4x4 instance for directed scenarios
// and a default 16x16 instance for a full ramp frame with toggling out_ready.
module tb_sobel_window_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        s_clear = 1'b0;
  logic [7:0]  s_pix = '0;
  logic        s_in_valid = 1'b0;
  logic        s_in_ready;
  logic [71:0] s_win;
  logic        s_out_valid;
  logic        s_out_ready = 1'b1;
  logic        s_frame_done;

  logic        b_clear = 1'b0;
  logic [7:0]  b_pix = '0;
  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic [71:0] b_win;
  logic        b_out_valid;
  logic        b_out_ready = 1'b1;
  logic        b_frame_done;

  int n_cmp = 0;
  int n_fail = 0;
  int s_win_cnt = 0;
  int s_fd_cnt = 0;
  int b_win_cnt = 0;
  int b_fd_cnt = 0;

  logic [71:0] q_s[$];
  logic [71:0] q_b[$];
  logic [7:0]  img [2][16][16];
  int          cur_r[2];
  int          cur_c[2];

  always #5 clk = ~clk;

  sobel_window_gen #(.bitwidth(8), .IMG_W(4), .IMG_H(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .clear(s_clear), .pix_in(s_pix),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .win_out(s_win),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .frame_done(s_frame_done)
  );

  sobel_window_gen dut_big (
    .clk(clk), .rst_n(rst_n), .clear(b_clear), .pix_in(b_pix),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .win_out(b_win),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .frame_done(b_frame_done)
  );

  task automatic check_output(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [71:0] pack9(input int a0, input int a1, input int a2,
                                        input int a3, input int a4, input int a5,
                                        input int a6, input int a7, input int a8);
    int v[9];
    logic [71:0] f;
    v = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
    f = '0;
    for (int k = 0; k < 9; k++) f[k*8 +: 8] = v[k][7:0];
    return f;
  endfunction

  // Offers one pixel until the DUT takes it; the bench's own image model then
  // predicts the window whenever the accepted pixel is a bottom-right corner.
  task automatic apply_stimulus(input bit big, input logic [7:0] v);
    bit accepted;
    int w, h, r, c;
    logic [71:0] e;
    accepted = 0;
    if (big) begin b_pix = v; b_in_valid = 1'b1; end
    else begin s_pix = v; s_in_valid = 1'b1; end
    for (int t = 0; t < 64 && !accepted; t++) begin
      if (big) b_out_ready = ~b_out_ready;
      @(negedge clk);
      if (big ? b_in_ready : s_in_ready) accepted = 1;
      else begin @(posedge clk); #1; end
    end
    if (!accepted) begin
      check_output("accept_timeout", 72'(0), 72'(1));
    end else begin
      w = big ? 16 : 4;
      h = big ? 16 : 4;
      r = cur_r[big];
      c = cur_c[big];
      img[big][r][c] = v;
      if (r >= 2 && c >= 2) begin
        for (int k = 0; k < 9; k++) e[k*8 +: 8] = img[big][r-2+k/3][c-2+k%3];
        if (big) q_b.push_back(e); else q_s.push_back(e);
      end
      c++;
      if (c == w) begin
        c = 0;
        r++;
        if (r == h) r = 0;
      end
      cur_r[big] = r;
      cur_c[big] = c;
    end
    @(posedge clk); #1;
    if (big) b_in_valid = 1'b0; else s_in_valid = 1'b0;
  endtask

  // One full 4x4 frame with pixel values base+index and timing spot checks
  task automatic run_small_frame(input int base, input bit gaps);
    int w0, f0;
    w0 = s_win_cnt;
    f0 = s_fd_cnt;
    for (int i = 0; i < 16; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
      apply_stimulus(0, 8'(base + i));
      if (i < 10) check_output("no_early_window", 72'(s_out_valid), 72'(0));
      if (i == 10) begin
        check_output("first_valid", 72'(s_out_valid), 72'(1));
        check_output("first_window", s_win, pack9(base+0, base+1, base+2, base+4,
                     base+5, base+6, base+8, base+9, base+10));
      end
      if (i == 11 && !gaps)
        check_output("second_window", s_win, pack9(base+1, base+2, base+3, base+5,
                     base+6, base+7, base+9, base+10, base+11));
      if (i == 14) check_output("fd_before_last", 72'(s_frame_done), 72'(0));
      if (i == 15) begin
        check_output("last_window", s_win, pack9(base+5, base+6, base+7, base+9,
                     base+10, base+11, base+13, base+14, base+15));
        check_output("fd_pulse", 72'(s_frame_done), 72'(1));
      end
    end
    @(posedge clk); #1;
    check_output("fd_one_cycle", 72'(s_frame_done), 72'(0));
    repeat (3) @(posedge clk);
    #1;
    check_output("windows_per_frame", 72'(s_win_cnt - w0), 72'(4));
    check_output("fd_per_frame", 72'(s_fd_cnt - f0), 72'(1));
  endtask

  // Monitor: every handshake on the output side pops one predicted window
  always @(negedge clk) begin
    if (rst_n && s_out_valid && s_out_ready) begin
      if (q_s.size() == 0) check_output("small_unexpected_window", s_win, 72'(0) - 72'(1));
      else check_output("small_window", s_win, q_s.pop_front());
      s_win_cnt++;
    end
    if (rst_n && s_frame_done) s_fd_cnt++;
    if (rst_n && b_out_valid && b_out_ready) begin
      if (q_b.size() == 0) check_output("big_unexpected_window", b_win, 72'(0) - 72'(1));
      else check_output("big_window", b_win, q_b.pop_front());
      b_win_cnt++;
    end
    if (rst_n && b_frame_done) b_fd_cnt++;
  end

  initial begin
    int w0, f0;
    cur_r = '{0, 0};
    cur_c = '{0, 0};
    #23 rst_n = 1'b1;
    @(posedge clk); #1;
    check_output("reset_out_valid", 72'(s_out_valid), 72'(0));
    check_output("reset_win_out", s_win, 72'(0));
    check_output("reset_frame_done", 72'(s_frame_done), 72'(0));
    check_output("reset_in_ready", 72'(s_in_ready), 72'(1));

    $display("[TB] scenario 1: straight 4x4 frame");
    run_small_frame(0, 0);

    $display("[TB] scenario 2: backpressure after first window");
    for (int i = 0; i <= 10; i++) apply_stimulus(0, 8'(i));
    s_out_ready = 1'b0;
    s_pix = 8'd11;
    s_in_valid = 1'b1;
    for (int t = 0; t < 5; t++) begin
      @(posedge clk); #1;
      check_output("bp_in_ready", 72'(s_in_ready), 72'(0));
      check_output("bp_out_valid", 72'(s_out_valid), 72'(1));
      check_output("bp_hold", s_win, pack9(0, 1, 2, 4, 5, 6, 8, 9, 10));
    end
    s_out_ready = 1'b1;
    apply_stimulus(0, 8'd11);
    check_output("bp_next_window", s_win, pack9(1, 2, 3, 5, 6, 7, 9, 10, 11));
    for (int i = 12; i < 16; i++) apply_stimulus(0, 8'(i));
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] scenario 3: random gaps over two frames");
    run_small_frame(0, 1);
    run_small_frame(100, 1);

    $display("[TB] scenario 4: clear mid-frame");
    for (int i = 0; i < 6; i++) apply_stimulus(0, 8'(50 + i));
    s_clear = 1'b1;
    s_in_valid = 1'b1;
    s_pix = 8'd99;
    @(posedge clk); #1;
    s_clear = 1'b0;
    s_in_valid = 1'b0;
    cur_r[0] = 0;
    cur_c[0] = 0;
    check_output("clear_out_valid", 72'(s_out_valid), 72'(0));
    check_output("clear_frame_done", 72'(s_frame_done), 72'(0));
    run_small_frame(0, 0);

    $display("[TB] scenario 5: asynchronous reset while a window is held");
    for (int i = 0; i <= 10; i++) apply_stimulus(0, 8'(i));
    s_out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_output("async_rst_out_valid", 72'(s_out_valid), 72'(0));
    check_output("async_rst_win_out", s_win, 72'(0));
    q_s.delete();
    cur_r[0] = 0;
    cur_c[0] = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    s_out_ready = 1'b1;
    run_small_frame(0, 0);

    $display("[TB] scenario 6: 16x16 ramp with toggling out_ready");
    w0 = b_win_cnt;
    f0 = b_fd_cnt;
    for (int i = 0; i < 256; i++) apply_stimulus(1, 8'(i));
    b_out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_output("big_window_count", 72'(b_win_cnt - w0), 72'(196));
    check_output("big_frame_done", 72'(b_fd_cnt - f0), 72'(1));

    check_output("small_queue_empty", 72'(q_s.size()), 72'(0));
    check_output("big_queue_empty", 72'(q_b.size()), 72'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
